// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response and APB requester signal bundle for apb_master
interface apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester driven by a valid/ready command port
// Optional ACCESS wait-state timeout enabled by defining APB_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  cmd_ready;
    logic                  handshake;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Ready is forced low while reset is held, even though the state already reads IDLE.
    always_comb begin
        cmd_ready = 1'b0;
        if (!PRESET) begin
            case (state_q)
                IDLE:    cmd_ready = 1'b1;
                ACCESS:  cmd_ready = bus.PREADY;
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    assign handshake = bus.cmd_valid & cmd_ready;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: ;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // A handshake in ACCESS overrides the return to IDLE, giving the 2-cycle back-to-back rate.
        if (handshake) begin
            state_d    = SETUP;
            paddr_d    = bus.cmd_addr;
            pwdata_d   = bus.cmd_wdata;
            pwrite_d   = bus.cmd_write;
`ifdef APB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.PSEL      = (state_q != IDLE);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of cmd_addr and PADDR.
REQ-002 Parameter DATA_WIDTH, default 8, width of cmd_wdata, PWDATA, PRDATA and rsp_rdata.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, number of ACCESS wait cycles before abort; used only under APB_TIMEOUT_EN.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; port PCLK, input, 1, the single clock; all state changes on rising edge.
REQ-005 Port PRESET, input, 1, asynchronous active-high reset.
REQ-006 Port cmd_valid, input, 1, a command is offered.
REQ-007 Port cmd_ready, output, 1, the master accepts the command this cycle.
REQ-008 Port cmd_write, input, 1, 1 = write, 0 = read.
REQ-009 Port cmd_addr, input, ADDR_WIDTH, target address.
REQ-010 Port cmd_wdata, input, DATA_WIDTH, write data.
REQ-011 Port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 Port rsp_rdata, output, DATA_WIDTH, read data; 0 for writes and errors.
REQ-013 Port rsp_err, output, 1, transfer aborted by timeout.
REQ-014 Ports PSEL, PENABLE and PWRITE, output, 1 each; PADDR, output, ADDR_WIDTH; PWDATA, output, DATA_WIDTH: the APB requester signals.
REQ-015 Ports PRDATA, input, DATA_WIDTH, and PREADY, input, 1: the APB completer response.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-017 cmd_ready SHALL be 1 in IDLE, 1 in ACCESS while PREADY=1, and 0 otherwise.
REQ-018 A handshake occurs when cmd_valid and cmd_ready are both 1 at a rising edge. At that edge the block SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA and enter SETUP.
REQ-019 In SETUP: PSEL=1 and PENABLE=0; after exactly one cycle the FSM goes to ACCESS unconditionally.
REQ-020 In ACCESS: PSEL=1 and PENABLE=1. PADDR, PWRITE and PWDATA SHALL remain stable until the transfer completes.
REQ-021 ACCESS with PREADY=0 SHALL hold the state (wait state).
REQ-022 The transfer completes at a rising edge in ACCESS with PREADY=1. The FSM then goes to SETUP if a new handshake occurs at that edge, else to IDLE with PSEL=0 and PENABLE=0.
REQ-023 On completion, the cycle after the completing edge SHALL have rsp_valid=1 and rsp_err=0. rsp_rdata SHALL be the PRDATA sampled at the completing edge for reads, and 0 for writes.
REQ-024 rsp_valid SHALL be 1 for exactly one cycle per transfer, with no backpressure.
REQ-025 rsp_rdata and rsp_err SHALL hold their values until the next response.
REQ-026 Latency with zero wait states: handshake at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3. Each wait state adds one cycle.
REQ-027 Back-to-back transfers SHALL sustain one transfer per 2 cycles with PREADY=1.
REQ-028 In IDLE, PADDR, PWRITE and PWDATA SHALL retain their last registered values.

Reset
REQ-029 While PRESET=1, the block SHALL immediately, without a clock, force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and the timeout counter to 0.
REQ-030 cmd_ready SHALL be 0 while PRESET=1.
REQ-031 Reset asserted mid-transfer SHALL drop the transfer with no response pulse.

Configuration
REQ-032 Macro APB_TIMEOUT_EN defined: a counter SHALL count consecutive ACCESS cycles with PREADY=0.
REQ-033 With APB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES the FSM SHALL go to IDLE with PSEL=0 and PENABLE=0. The next cycle SHALL have rsp_valid=1, rsp_err=1 and rsp_rdata=0.
REQ-034 With APB_TIMEOUT_EN, the counter SHALL clear on entering SETUP.
REQ-035 Macro APB_TIMEOUT_EN undefined: the counter SHALL be absent, ACCESS SHALL wait indefinitely, and rsp_err SHALL be constant 0.

Verification
REQ-036 Write 0x01/0xAA, PREADY=1: PSEL rises the cycle after the handshake, PENABLE one cycle later, PADDR=0x01, PWDATA=0xAA, PWRITE=1; rsp_valid=1 with rsp_rdata=0 three cycles after the handshake.
REQ-037 Read 0x03 with PREADY=0 for 2 ACCESS cycles, then PRDATA=0xFF and PREADY=1: PENABLE is high for 3 cycles; rsp_valid=1 with rsp_rdata=0xFF; PADDR is stable throughout.
REQ-038 Writes 0x01/0xAA, 0x02/0x4A, 0x03/0xFF, 0x04/0x33 offered back-to-back with PREADY=1: PSEL stays high continuously; PENABLE toggles every cycle; four rsp_valid pulses 2 cycles apart.
REQ-039 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0: PSEL drops after 16 ACCESS cycles; rsp_valid=1 with rsp_err=1; the next command is then accepted.
REQ-040 PRESET asserted during ACCESS of a read: PSEL, PENABLE and all outputs are 0 in the same cycle; no rsp_valid; after release a new write completes normally.
